// File: rtl/hazard_stall_controller.sv
// Hazard and stall controller for a five-stage pipeline with a multi-cycle MDU.
// Detects load-use and branch operand hazards, sequences MDU waits, gates
// ID-stage redirects, and counts stalled cycles.
module hazard_stall_controller #(
   parameter int unsigned REGFILE_LEN = 6,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INSTR_WIDTH-1:0] instr_IF_ID,
   input  logic [REGFILE_LEN-1:0] rs1_IF_ID,
   input  logic [REGFILE_LEN-1:0] rs2_IF_ID,
   input  logic [REGFILE_LEN-1:0] rd_ID_EX,
   input  logic [REGFILE_LEN-1:0] rd_EX_MEM,
   input  logic                   reg_write_ID_EX,
   input  logic                   mem_read_ID_EX,
   input  logic                   mem_read_EX_MEM,
   input  logic                   branch_taken_ID,
   input  logic                   mdu_req_ID_EX,
   input  logic                   mdu_done,
   output logic                   mdu_start,
   output logic                   stall_PC,
   output logic                   stall_IF_ID,
   output logic                   stall_ID_EX,
   output logic                   flush_IF_ID,
   output logic                   flush_ID_EX,
   output logic                   flush_EX_MEM,
   output logic [CNT_WIDTH-1:0]   stall_cycles
);

   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   typedef enum logic [0:0] {StRun, StMduWait} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_cycles_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       rs1_used, rs2_used, is_branch;
   logic       match_id_ex, match_ex_mem;
   logic       load_use, branch_hazard;

   // Fields of the instruction not involved in hazard decode.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr_IF_ID[INSTR_WIDTH-1:15], instr_IF_ID[11:7]};

   // Decode which sources the ID instruction reads and compare against older writers.
   always_comb begin
      opcode   = instr_IF_ID[6:0];
      funct3   = instr_IF_ID[14:12];
      rs1_used = (opcode == OpReg)   || (opcode == OpImm)    || (opcode == OpLoad) ||
                 (opcode == OpStore) || (opcode == OpBranch) || (opcode == OpJalr);
      rs2_used = (opcode == OpReg)   || (opcode == OpStore)  || (opcode == OpBranch);
      is_branch = (opcode == OpBranch) || ((opcode == OpJalr) && (funct3 == 3'b000));
      // x0 is hard-wired, so it never creates a dependency.
      match_id_ex  = (rs1_used && (rs1_IF_ID != '0) && (rs1_IF_ID == rd_ID_EX)) ||
                     (rs2_used && (rs2_IF_ID != '0) && (rs2_IF_ID == rd_ID_EX));
      match_ex_mem = (rs1_used && (rs1_IF_ID != '0) && (rs1_IF_ID == rd_EX_MEM)) ||
                     (rs2_used && (rs2_IF_ID != '0) && (rs2_IF_ID == rd_EX_MEM));
      load_use      = mem_read_ID_EX && match_id_ex;
      // Branches resolve in ID, so they also wait on ALU results and loads still in MEM.
      branch_hazard = is_branch && ((reg_write_ID_EX && match_id_ex) ||
                                    (mem_read_EX_MEM && match_ex_mem));
   end

   // Next-state and stall/flush outputs, prioritised MDU > branch > load-use > redirect.
   always_comb begin
      state_d      = state_q;
      mdu_start    = 1'b0;
      stall_PC     = 1'b0;
      stall_IF_ID  = 1'b0;
      stall_ID_EX  = 1'b0;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_EX_MEM = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            StRun: begin
               if (mdu_req_ID_EX) begin
                  mdu_start    = 1'b1;
                  stall_PC     = 1'b1;
                  stall_IF_ID  = 1'b1;
                  stall_ID_EX  = 1'b1;
                  flush_EX_MEM = 1'b1;
                  state_d      = StMduWait;
               end else if (branch_hazard || load_use) begin
                  stall_PC    = 1'b1;
                  stall_IF_ID = 1'b1;
                  flush_ID_EX = 1'b1;
               end else begin
                  flush_IF_ID = branch_taken_ID;
               end
            end
            StMduWait: begin
               if (mdu_done) begin
                  state_d = StRun;
               end else begin
                  stall_PC     = 1'b1;
                  stall_IF_ID  = 1'b1;
                  stall_ID_EX  = 1'b1;
                  flush_EX_MEM = 1'b1;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   // State register; reset abandons any MDU wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else if (stall_PC && (stall_cycles_q != '1)) begin
         stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule
